core_mem: RTL and testbench
===========================

# core_mem

Byte-wide program/data memory with a serial program-load front end, sitting directly upstream of the stack-machine core. Its combinational read port feeds the core's `data_in`. Its write port is driven by the core's `mem_addr`/`data_out` plus an explicit store strobe. It holds the core in reset until a program has been loaded. Two I/O addresses at the top of the 8-bit map give the core an input port and a latched output port.

## Interface
- `DEPTH`, 32: bytes of RAM at addresses 0..DEPTH-1; power of two, 2..128.
- `IN_ADDR`, 8'hFE: address that reads `ext_in`.
- `OUT_ADDR`, 8'hFF: address that writes `out_port`.
- `clock`  in  1  single clock; all state updates on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `mem_addr`  in  8  core address, read and write.
- `rd_data`  out  8  combinational read data to the core's `data_in`.
- `wr_en`  in  1  core store strobe; writes `wr_data` to `mem_addr` this edge.
- `wr_data`  in  8  core store data, from the core's `data_out`.
- `load_start`  in  1  one-cycle pulse; begins a program load.
- `load_valid`  in  1  `load_data` is valid.
- `load_data`  in  8  program byte.
- `load_ready`  out  1  block accepts a byte this cycle.
- `load_done`  in  1  host marks the end of the program.
- `core_reset`  out  1  active-high synchronous reset for the core.
- `loaded_len`  out  8  number of bytes written by the last load.
- `ext_in`  in  8  external input port value.
- `out_port`  out  8  last byte stored to `OUT_ADDR`.
- `out_valid`  out  1  one-cycle pulse after each store to `OUT_ADDR`.

## Operation
- FSM states: IDLE, LOAD, RUN. Reset enters IDLE.
- **IDLE:**
  - `core_reset`=1, `load_ready`=0.
  - `load_start` → LOAD, with `ptr`=0 and `loaded_len`=0.
- **LOAD:**
  - `core_reset`=1, `load_ready`=1.
  - On `load_valid`&&`load_ready`: `mem[ptr]`←`load_data`, `ptr`++, `loaded_len`++.
  - Load completes when `load_done`=1, or when the accepted byte lands at `ptr`=DEPTH-1 (memory full). On completion → RUN.
  - If `load_done` and an accepted byte occur in the same cycle, the byte is written, then the block moves to RUN.
  - `load_start` while in LOAD restarts the load: `ptr`=0, `loaded_len`=0. Any byte offered in that same cycle is dropped.
- **RUN:**
  - `core_reset`=0, `load_ready`=0.
  - `load_start` → LOAD, reasserting `core_reset` on the next cycle.
- Core writes are honoured only in RUN. `wr_en` in IDLE or LOAD is ignored.
- Address decode, for both reads and writes:
  - addr < DEPTH: RAM.
  - addr == `IN_ADDR`: reads return `ext_in`; writes are ignored.
  - addr == `OUT_ADDR`: reads return `out_port`; writes latch `out_port` and pulse `out_valid`.
  - Any other address: reads return 8'h00; writes are ignored.
- `ptr` is log2(DEPTH) bits wide and never wraps, because reaching the last location ends the load.
- `loaded_len` saturates at DEPTH.

## Timing
- Read latency is 0 cycles: `rd_data` is a pure function of `mem_addr` and current state. The core samples it in the same cycle it drives the address.
- A write (core or load) is visible on `rd_data` from the cycle after the write edge.
- `out_valid` is high for exactly the one cycle after the write edge. `out_port` updates on that same edge.
- `core_reset` is registered: it deasserts on the first RUN cycle and asserts on the first LOAD cycle.
- **Async reset:**
  - Clears RAM to 8'h00.
  - `state`=IDLE, `ptr`=0.
  - Output reset values: `core_reset`=1, `load_ready`=0, `loaded_len`=0, `out_port`=0, `out_valid`=0.
  - `rd_data` follows decode of the cleared RAM.
- **Reset mid-load:** the partial program is discarded (RAM cleared) and the block returns to IDLE.
- **Reset during a core store:** the store is lost.

## Structure
- Shared package `core_mem_pkg`: state enum `mem_state_e` {IDLE, LOAD, RUN}, and default `IN_ADDR`/`OUT_ADDR` localparams shared with the core's assembler constants.
- Sub-module `mem_array` holds the RAM:
  - DEPTH×8 flops with async clear.
  - One synchronous write port and one combinational read port.
  - Its write mux selects the load port in LOAD and the core port in RUN.
- FSM, address decode and I/O registers live in `core_mem`.

## Test plan
- **Load then run:** reset, `load_start`, bytes 8'h08,8'h05,8'h0E, then `load_done` → `loaded_len`=3, `core_reset` falls one cycle later, `rd_data`@0=8'h08, @2=8'h0E.
- **Full load:** DEPTH=32, stream 40 bytes with no `load_done` → exactly 32 accepted, `load_ready` low from cycle 33, state RUN, `loaded_len`=32.
- **I/O:** in RUN, `wr_en` to 8'hFF with 8'h5A → `out_port`=8'h5A and a single-cycle `out_valid`. Read 8'hFE with `ext_in`=8'h3C → `rd_data`=8'h3C. Read 8'h80 → 8'h00.
- **Write gating:** `wr_en` to address 4 during LOAD → `mem[4]` unchanged. The same write in RUN → `rd_data`@4 is the new value from the next cycle.
- **Restart:** `load_start` in mid-RUN → `core_reset`=1 next cycle, `ptr`=0, the new bytes overwrite from address 0, untouched locations retain old data.
- **Async reset during LOAD:** assert `reset_n`=0 between clock edges → outputs reach their reset values immediately, RAM reads 8'h00, and the next `load_start` works normally.

Source files
------------

// File: rtl/core_mem_pkg.sv
// Shared definitions for the program/data memory in front of the stack-machine core.
// The I/O addresses must match the core's assembler constants.
package core_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } mem_state_e;

  localparam logic [7:0] DEFAULT_IN_ADDR  = 8'hFE;
  localparam logic [7:0] DEFAULT_OUT_ADDR = 8'hFF;

endpackage

// File: rtl/mem_array.sv
// DEPTH x 8 RAM built from clearable flops: one synchronous write port whose source
// is the program loader or the core, and one combinational read port.
module mem_array #(
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          load_sel,
  input  logic          load_we,
  input  logic [AW-1:0] load_addr,
  input  logic [7:0]    load_data,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [7:0]    core_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0]    mem [DEPTH];
  logic          we;
  logic [AW-1:0] waddr;
  logic [7:0]    wdata;

  always_comb begin
    we    = load_sel ? load_we   : core_we;
    waddr = load_sel ? load_addr : core_addr;
    wdata = load_sel ? load_data : core_data;
  end

  // NOTE: the RAM is flops, not a macro, so it can take the async clear; a reset
  // wipes any partial program and the core always starts from a known image.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/core_mem.sv
// Program/data memory for the stack-machine core: serial program loader, core
// read/write port, memory-mapped input and latched output ports, core reset hold-off.
module core_mem
  import core_mem_pkg::*;
#(
  parameter int         DEPTH    = 32,
  parameter logic [7:0] IN_ADDR  = DEFAULT_IN_ADDR,
  parameter logic [7:0] OUT_ADDR = DEFAULT_OUT_ADDR
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] mem_addr,
  output logic [7:0] rd_data,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       load_start,
  input  logic       load_valid,
  input  logic [7:0] load_data,
  output logic       load_ready,
  input  logic       load_done,
  output logic       core_reset,
  output logic [7:0] loaded_len,
  input  logic [7:0] ext_in,
  output logic [7:0] out_port,
  output logic       out_valid
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);
  localparam logic [7:0]    LEN_MAX = 8'(DEPTH);
  localparam logic [8:0]    RAM_TOP = 9'(DEPTH);

  mem_state_e    state, next_state;
  logic [AW-1:0] ptr;
  logic [7:0]    ram_rd;
  logic          accept, finish, in_ram, core_we, out_we;

  // A restart pulse in LOAD takes priority: the byte offered alongside it is dropped.
  assign accept  = (state == LOAD) && load_valid && !load_start;
  assign finish  = (state == LOAD) && !load_start && (load_done || (accept && ptr == LAST));
  assign in_ram  = {1'b0, mem_addr} < RAM_TOP;
  assign core_we = (state == RUN) && wr_en && in_ram;
  assign out_we  = (state == RUN) && wr_en && (mem_addr == OUT_ADDR);

  // NOTE: all state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // NOTE: next_state gets its default before the case, so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (load_start) next_state = LOAD;
      LOAD:    if (finish)     next_state = RUN;
      RUN:     if (load_start) next_state = LOAD;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    load_ready = (state == LOAD);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr        <= '0;
      loaded_len <= '0;
      core_reset <= 1'b1;
      out_port   <= '0;
      out_valid  <= 1'b0;
    end else begin
      if (load_start) begin
        ptr        <= '0;
        loaded_len <= '0;
      end else if (accept) begin
        if (ptr != LAST)           ptr        <= ptr + AW'(1);
        if (loaded_len != LEN_MAX) loaded_len <= loaded_len + 8'd1;
      end
      core_reset <= (next_state != RUN);
      out_valid  <= out_we;
      if (out_we) out_port <= wr_data;
    end
  end

  mem_array #(.DEPTH(DEPTH), .AW(AW)) u_mem_array (
    .clock     (clock),
    .reset_n   (reset_n),
    .load_sel  (state == LOAD),
    .load_we   (accept),
    .load_addr (ptr),
    .load_data (load_data),
    .core_we   (core_we),
    .core_addr (mem_addr[AW-1:0]),
    .core_data (wr_data),
    .rd_addr   (mem_addr[AW-1:0]),
    .rd_data   (ram_rd)
  );

  always_comb begin
    if (in_ram)                    rd_data = ram_rd;
    else if (mem_addr == IN_ADDR)  rd_data = ext_in;
    else if (mem_addr == OUT_ADDR) rd_data = out_port;
    else                           rd_data = 8'h00;
  end

endmodule

// File: tb/tb_core_mem.sv
// Randomised and directed bench for core_mem against a cycle-level behavioural model
// built from the memory's load/run rules and its address map.
module tb_core_mem;

  localparam int DEPTH = 32;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [7:0] mem_addr, rd_data, wr_data, load_data, loaded_len, ext_in, out_port;
  logic       wr_en, load_start, load_valid, load_ready, load_done, core_reset, out_valid;

  core_mem #(.DEPTH(DEPTH), .IN_ADDR(8'hFE), .OUT_ADDR(8'hFF)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .mem_addr   (mem_addr),
    .rd_data    (rd_data),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .load_start (load_start),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .load_done  (load_done),
    .core_reset (core_reset),
    .loaded_len (loaded_len),
    .ext_in     (ext_in),
    .out_port   (out_port),
    .out_valid  (out_valid)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: mode 0 = waiting for a program, 1 = loading, 2 = core running.
  int         m_mode, m_ptr, m_len;
  logic [7:0] m_mem [DEPTH];
  logic [7:0] m_out;
  logic       m_outv;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_ptr = 0; m_len = 0; m_out = 8'h00; m_outv = 1'b0;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;
  endtask

  function automatic logic [7:0] model_read(input logic [7:0] a);
    if (int'(a) < DEPTH) return m_mem[int'(a)];
    if (a == 8'hFE)      return ext_in;
    if (a == 8'hFF)      return m_out;
    return 8'h00;
  endfunction

  task automatic model_edge();
    m_outv = 1'b0;
    case (m_mode)
      0: if (load_start) begin m_mode = 1; m_ptr = 0; m_len = 0; end
      1: begin
        if (load_start) begin
          m_ptr = 0; m_len = 0;
        end else begin
          if (load_valid) begin
            m_mem[m_ptr] = load_data;
            m_ptr++;
            m_len = (m_len < DEPTH) ? m_len + 1 : DEPTH;
            if (m_ptr == DEPTH) m_mode = 2;
          end
          if (load_done) m_mode = 2;
        end
      end
      default: begin
        if (wr_en) begin
          if (int'(mem_addr) < DEPTH) m_mem[int'(mem_addr)] = wr_data;
          else if (mem_addr == 8'hFF) begin m_out = wr_data; m_outv = 1'b1; end
        end
        if (load_start) begin m_mode = 1; m_ptr = 0; m_len = 0; end
      end
    endcase
  endtask

  task automatic check_regs();
    check("core_reset", core_reset, m_mode != 2);
    check("load_ready", load_ready, m_mode == 1);
    check("loaded_len", loaded_len, m_len);
    check("out_port",   out_port,   m_out);
    check("out_valid",  out_valid,  m_outv);
  endtask

  // Inputs were set just after the previous edge; check the read port, clock, check state.
  task automatic cycle();
    #1;
    check("rd_data", rd_data, model_read(mem_addr));
    @(posedge clock);
    model_edge();
    #1;
    check_regs();
  endtask

  task automatic idle_inputs();
    wr_en = 0; wr_data = 0; load_start = 0; load_valid = 0; load_data = 0; load_done = 0;
  endtask

  task automatic read_at(input logic [7:0] a, input logic [7:0] exp, input string tag);
    mem_addr = a;
    #1;
    check(tag, rd_data, exp);
    check("rd_model", rd_data, model_read(a));
  endtask

  logic [7:0] prog [3];

  initial begin
    reset_n = 1'b0; mem_addr = 0; ext_in = 8'h3C;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clock);
    #2 reset_n = 1'b1;
    @(posedge clock); #1;
    check_regs();
    read_at(8'h00, 8'h00, "reset_ram");

    // Load then run: three-byte program ended by load_done.
    prog[0] = 8'h08; prog[1] = 8'h05; prog[2] = 8'h0E;
    load_start = 1; cycle(); load_start = 0;
    for (int i = 0; i < 3; i++) begin
      load_valid = 1; load_data = prog[i]; cycle();
    end
    load_valid = 0; load_done = 1; cycle(); load_done = 0;
    check("len3", loaded_len, 3);
    check("run_core_reset", core_reset, 0);
    read_at(8'h00, 8'h08, "prog0");
    read_at(8'h02, 8'h0E, "prog2");

    // I/O ports.
    mem_addr = 8'hFF; wr_en = 1; wr_data = 8'h5A; cycle(); wr_en = 0;
    check("out_port_5a", out_port, 8'h5A);
    check("out_valid_hi", out_valid, 1);
    cycle();
    check("out_valid_lo", out_valid, 0);
    read_at(8'hFE, 8'h3C, "ext_in");
    read_at(8'h80, 8'h00, "unmapped");

    // Write gating: a store during LOAD is ignored, the same store in RUN lands.
    load_start = 1; cycle(); load_start = 0;
    mem_addr = 8'h04; wr_en = 1; wr_data = 8'hA7; cycle(); wr_en = 0;
    load_done = 1; cycle(); load_done = 0;
    read_at(8'h04, 8'h00, "gated_write");
    wr_en = 1; wr_data = 8'hA7; cycle(); wr_en = 0;
    read_at(8'h04, 8'hA7, "run_write");

    // Restart mid-run overwrites from 0; untouched locations keep old data.
    load_start = 1; cycle(); load_start = 0;
    check("restart_core_reset", core_reset, 1);
    load_valid = 1; load_data = 8'h77; cycle(); load_valid = 0;
    load_done = 1; cycle(); load_done = 0;
    read_at(8'h00, 8'h77, "restart_new");
    read_at(8'h02, 8'h0E, "restart_old");

    // Full load: 40 bytes offered, only DEPTH accepted.
    load_start = 1; cycle(); load_start = 0;
    for (int i = 0; i < 40; i++) begin
      load_valid = 1; load_data = 8'(i + 8'h40); cycle();
    end
    load_valid = 0;
    check("full_len", loaded_len, DEPTH);
    check("full_ready", load_ready, 0);
    read_at(8'h1F, 8'h5F, "full_last");

    // Async reset asserted between edges during a load.
    load_start = 1; cycle(); load_start = 0;
    load_valid = 1; load_data = 8'hC3; cycle(); load_valid = 0;
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check_regs();
    read_at(8'h00, 8'h00, "async_ram");
    #1 reset_n = 1'b1;
    load_start = 1; cycle(); load_start = 0;
    load_valid = 1; load_data = 8'h99; cycle(); load_valid = 0;
    load_done = 1; cycle(); load_done = 0;
    read_at(8'h00, 8'h99, "reload");

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      int sel;
      load_start = ($urandom_range(0, 15) == 0);
      load_valid = $urandom_range(0, 1);
      load_data  = 8'($urandom);
      load_done  = ($urandom_range(0, 7) == 0);
      wr_en      = $urandom_range(0, 1);
      wr_data    = 8'($urandom);
      ext_in     = 8'($urandom);
      sel        = $urandom_range(0, 7);
      if (sel < 4)       mem_addr = 8'($urandom_range(0, DEPTH - 1));
      else if (sel == 4) mem_addr = 8'hFE;
      else if (sel == 5) mem_addr = 8'hFF;
      else               mem_addr = 8'($urandom);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
